// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned fetches, buffers one response
// in a skid entry when RD stalls, and drains the in-flight request on a redirect.
//
// state | meaning
// FETCH | request issued or about to be issued
// HOLD  | skid entry full, RD stalled, no request
// DRAIN | discard one in-flight response, pending target in drain_tgt
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_rd,
    input  logic        redirect_ex,
    input  logic [31:0] target_ex,
    output logic [31:0] ins_rd,
    output logic [31:0] pc_rd,
    output logic        valid_rd
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_f, pc_f_n;
    logic [31:0] skid_ins, skid_ins_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic        skid_v, skid_v_n;
    logic [31:0] drain_tgt, drain_tgt_n;
    logic        req_armed;
    logic [31:0] ins_rd_n, pc_rd_n;
    logic        valid_rd_n;

    logic [31:0] redirect_pc;
    logic [31:0] pc_inc;
    logic        hs;

    // Requests start one edge after reset release so a stale ACK is never taken.
    assign imem_req    = req_armed && (state != HOLD);
    assign imem_addr   = pc_f;
    assign redirect_pc = target_ex & 32'hFFFF_FFFC;
    assign pc_inc      = pc_f + 32'd4;
    assign hs          = imem_req && imem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FETCH;
            pc_f      <= RESET_PC;
            skid_ins  <= NOP_WORD;
            skid_pc   <= 32'd0;
            skid_v    <= 1'b0;
            drain_tgt <= 32'd0;
            req_armed <= 1'b0;
            ins_rd    <= NOP_WORD;
            pc_rd     <= 32'd0;
            valid_rd  <= 1'b0;
        end else begin
            state     <= state_n;
            pc_f      <= pc_f_n;
            skid_ins  <= skid_ins_n;
            skid_pc   <= skid_pc_n;
            skid_v    <= skid_v_n;
            drain_tgt <= drain_tgt_n;
            req_armed <= 1'b1;
            ins_rd    <= ins_rd_n;
            pc_rd     <= pc_rd_n;
            valid_rd  <= valid_rd_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_f_n      = pc_f;
        skid_ins_n  = skid_ins;
        skid_pc_n   = skid_pc;
        skid_v_n    = skid_v;
        drain_tgt_n = drain_tgt;
        ins_rd_n    = ins_rd;
        pc_rd_n     = pc_rd;
        valid_rd_n  = valid_rd;

        if (redirect_ex) begin
            skid_v_n   = 1'b0;
            ins_rd_n   = NOP_WORD;
            valid_rd_n = 1'b0;
            // An unacknowledged request must keep its address; park the target.
            if (state != HOLD && imem_req && !imem_ack) begin
                state_n     = DRAIN;
                drain_tgt_n = redirect_pc;
            end else begin
                state_n = FETCH;
                pc_f_n  = redirect_pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (hs) begin
                        pc_f_n = pc_inc;
                        if (stall_rd) begin
                            skid_ins_n = imem_rdata;
                            skid_pc_n  = pc_f;
                            skid_v_n   = 1'b1;
                            state_n    = HOLD;
                        end else begin
                            ins_rd_n   = imem_rdata;
                            pc_rd_n    = pc_f;
                            valid_rd_n = 1'b1;
                        end
                    end else if (!stall_rd) begin
                        ins_rd_n   = NOP_WORD;
                        valid_rd_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_rd) begin
                        ins_rd_n   = skid_ins;
                        pc_rd_n    = skid_pc;
                        valid_rd_n = skid_v;
                        skid_v_n   = 1'b0;
                        state_n    = FETCH;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        pc_f_n  = drain_tgt;
                        state_n = FETCH;
                    end
                    if (!stall_rd) begin
                        ins_rd_n   = NOP_WORD;
                        valid_rd_n = 1'b0;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: accepted fetches are queued with their
// expected word and retired against the RD-stage outputs.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_rd;
    logic        redirect_ex;
    logic [31:0] target_ex;
    logic [31:0] ins_rd;
    logic [31:0] pc_rd;
    logic        valid_rd;

    logic        req2;
    logic [31:0] addr2, rdata2, ins2, pc2;
    logic        valid2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;
    item_t sb_q[$];

    logic [31:0] m_fpc, drop_addr, m_pc, m_ins;
    logic        m_armed, drop_pending, m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);

    fetch_unit dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall_rd(stall_rd), .redirect_ex(redirect_ex), .target_ex(target_ex),
        .ins_rd(ins_rd), .pc_rd(pc_rd), .valid_rd(valid_rd)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(1'b1), .imem_rdata(rdata2),
        .stall_rd(1'b0), .redirect_ex(1'b0), .target_ex(32'h0),
        .ins_rd(ins2), .pc_rd(pc2), .valid_rd(valid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_fpc        = 32'h0;
        m_armed      = 1'b0;
        drop_pending = 1'b0;
        drop_addr    = 32'h0;
        m_valid      = 1'b0;
        m_pc         = 32'h0;
        m_ins        = NOP;
    endtask

    // Entered at a falling edge; asserts reset mid-phase with a stale ACK present.
    task automatic do_reset();
        #2;
        imem_ack    = 1'b1;
        redirect_ex = 1'b0;
        stall_rd    = 1'b0;
        reset_n     = 1'b0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_valid_rd", {31'b0, valid_rd}, 32'h0);
        check("rst_ins_rd", ins_rd, NOP);
        check("rst_pc_rd", pc_rd, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic cycle(input logic ack, input logic stall, input logic redir,
                         input logic [31:0] tgt);
        logic  m_req, hs;
        item_t it;
        imem_ack    = ack;
        stall_rd    = stall;
        redirect_ex = redir;
        target_ex   = tgt;
        #1;
        m_req = m_armed && (sb_q.size() == 0);
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) check("imem_addr", imem_addr, drop_pending ? drop_addr : m_fpc);
        hs = m_req && ack;
        if (redir) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_ins   = NOP;
            if (hs) begin
                drop_pending = 1'b0;
            end else if (m_req && !drop_pending) begin
                drop_pending = 1'b1;
                drop_addr    = m_fpc;
            end
            m_fpc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (hs) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    sb_q.push_back('{pc: m_fpc, ins: mem_word(m_fpc)});
                    m_fpc = m_fpc + 32'd4;
                end
            end
            if (!stall) begin
                if (sb_q.size() > 0) begin
                    it      = sb_q.pop_front();
                    m_valid = 1'b1;
                    m_pc    = it.pc;
                    m_ins   = it.ins;
                end else begin
                    m_valid = 1'b0;
                    m_ins   = NOP;
                end
            end
        end
        @(posedge clk);
        m_armed = 1'b1;
        @(negedge clk);
        check("valid_rd", {31'b0, valid_rd}, {31'b0, m_valid});
        check("pc_rd", pc_rd, m_pc);
        check("ins_rd", ins_rd, m_ins);
    endtask

    initial begin
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        stall_rd    = 1'b0;
        redirect_ex = 1'b0;
        target_ex   = 32'h0;
        model_reset();
        @(negedge clk);

        // Streaming with ACK tied high; the wrap instance runs alongside.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (i == 1) check("wrap_pc0", pc2, 32'hFFFF_FFF8);
            if (i == 2) check("wrap_pc1", pc2, 32'hFFFF_FFFC);
            if (i == 3) begin
                check("wrap_pc2", pc2, 32'h0000_0000);
                check("wrap_ins2", ins2, mem_word(32'h0));
                check("wrap_valid", {31'b0, valid2}, 32'h1);
            end
        end

        // Stall three cycles starting with the ACK of 0x8.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("hold_ins", ins_rd, mem_word(32'h4));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect while 0x10 waits for ACK, then a double redirect in DRAIN.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("wait_addr", imem_addr, 32'h10);
        cycle(1'b0, 1'b0, 1'b1, 32'h103);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("drain_next_addr", imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h200);
        cycle(1'b0, 1'b0, 1'b1, 32'h300);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect with stall and ACK together, then redirect out of HOLD.
        cycle(1'b1, 1'b1, 1'b1, 32'h40);
        check("rs_valid", {31'b0, valid_rd}, 32'h0);
        check("rs_next_addr", imem_addr, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h81);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // PC wraps modulo 2^32.
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0, $urandom & 32'h0000_0FFF);

        // Reset asserted mid-DRAIN; stale ACK around release must be ignored.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h500);
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("post_rst_valid", {31'b0, valid_rd}, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
